bus_arbiter: RTL and testbench

Round-robin arbiter and bus-ownership controller for the shared single-wire serial bus. It takes access requests from up to NUM_MASTERS bus masters and grants the bus to exactly one at a time. It drives the shared `bus_util` line that slaves watch to leave WAIT_FOR_PEER, and it honours the wired-OR `slave_busy` line before handing the bus to a new master. A watchdog reclaims the bus from a master that stalls.

---
 rtl/bus_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared serial bus, with slave-busy deferral,
// a one-cycle release gap between owners and a stall watchdog.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ID_WIDTH       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] done,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   bus_util,
  output logic                   timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWNED   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [7:0]             STALL_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0]    LAST_RESET  = ID_WIDTH'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0    = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  logic [1:0]             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [ID_WIDTH-1:0]    r_grant_id;
  logic                   r_bus_util;
  logic                   r_timeout;
  logic [7:0]             r_stall;
  logic [ID_WIDTH-1:0]    r_last_owner;

  logic                   w_found;
  logic [ID_WIDTH-1:0]    w_winner;
  int                     w_idx;
  logic                   w_owner_done;
  logic                   w_owner_req;
  logic                   w_watchdog;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = {ID_WIDTH{1'b0}};
    w_idx    = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = (int'(r_last_owner) + i) % NUM_MASTERS;
      if (!w_found && |(req & (ONE_HOT0 << w_idx))) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'(w_idx);
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Owner-qualified exit conditions; other masters' done/req are masked off by the grant.
  always_comb begin
    w_owner_done = |(done & r_grant);
    w_owner_req  = |(req & r_grant);
    w_watchdog   = !slave_busy && (r_stall == STALL_LIMIT);
  end

  // Ownership state machine and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= {NUM_MASTERS{1'b0}};
      r_grant_id   <= {ID_WIDTH{1'b0}};
      r_bus_util   <= 1'b0;
      r_timeout    <= 1'b0;
      r_stall      <= 8'd0;
      r_last_owner <= LAST_RESET;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_stall <= 8'd0;
          if (!slave_busy && w_found) begin
            r_state      <= ST_OWNED;
            r_grant      <= ONE_HOT0 << w_winner;
            r_grant_id   <= w_winner;
            r_bus_util   <= 1'b1;
            r_last_owner <= w_winner;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWNED: begin
          // done beats abort beats watchdog; only the watchdog path flags timeout.
          if (w_owner_done || !w_owner_req || w_watchdog) begin
            r_state    <= ST_RELEASE;
            r_grant    <= {NUM_MASTERS{1'b0}};
            r_grant_id <= {ID_WIDTH{1'b0}};
            r_bus_util <= 1'b0;
            r_stall    <= 8'd0;
            r_timeout  <= !w_owner_done && w_owner_req;
          end else if (slave_busy) begin
            r_stall <= 8'd0;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_stall <= 8'd0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_grant    <= {NUM_MASTERS{1'b0}};
          r_grant_id <= {ID_WIDTH{1'b0}};
          r_bus_util <= 1'b0;
          r_stall    <= 8'd0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign bus_util = r_bus_util;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus a randomized run against an owner-index reference model.
module tb_bus_arbiter;

  localparam int N = 3;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] done = 3'b000;
  logic       slave_busy = 1'b0;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       bus_util;
  logic       timeout;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: who owns the bus (-1 = nobody), plus release gap and stall count.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_stall = 0;
  bit m_rel   = 1'b0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .slave_busy(slave_busy),
    .grant(grant), .grant_id(grant_id), .bus_util(bus_util), .timeout(timeout)
  );

  function automatic bit bit_at(logic [2:0] v, int i);
    logic [1:0] j;
    j = 2'(i);
    return v[j];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_stall = 0; m_rel = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (bit_at(done, m_owner) || !bit_at(req, m_owner)) begin
          m_owner = -1; m_rel = 1'b1; m_stall = 0;
        end else if (!slave_busy && m_stall == T - 1) begin
          m_owner = -1; m_rel = 1'b1; m_stall = 0; m_to = 1'b1;
        end else begin
          m_stall = slave_busy ? 0 : m_stall + 1;
        end
      end else if (m_rel) begin
        m_rel = 1'b0;
      end else if (!slave_busy && req != 3'b000) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && bit_at(req, (m_last + k) % N)) m_owner = (m_last + k) % N;
        end
        m_last = m_owner; m_stall = 0;
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [2:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
    return {g, id, (m_owner >= 0), m_to};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; done = 3'b000; slave_busy = 1'b0;
    step(); step();
    n_run++;
    if ({grant, grant_id, bus_util, timeout} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", {grant, grant_id, bus_util, timeout}, 7'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req = 3'b010;
    step();
    n_run++;
    if ({grant, grant_id, bus_util} !== 6'b010_01_1) begin
      n_fail++; $display("FAIL single_grant: got %b expected %b", {grant, grant_id, bus_util}, 6'b010_01_1);
    end
    done = 3'b010; req = 3'b000;
    step();
    done = 3'b000;
    n_run++;
    if ({grant, bus_util} !== 4'b0) begin
      n_fail++; $display("FAIL single_release: got %b expected %b", {grant, bus_util}, 4'b0);
    end
    step();
    n_run++;
    if (bus_util !== 1'b0) begin
      n_fail++; $display("FAIL single_gap: got %b expected 0", bus_util);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] order [4];
    int w;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    rst = 1'b1; step(); rst = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (grant === 3'b000 && w < 10) begin step(); w++; end
      n_run++;
      if (grant !== order[k]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", k, grant, order[k]);
      end
      if (k > 0) begin
        n_run++;
        if (w !== 2) begin
          n_fail++; $display("FAIL rr_gap[%0d]: got %0d idle cycles expected 2", k, w);
        end
      end
      repeat (4) step();
      n_run++;
      if (grant !== order[k]) begin
        n_fail++; $display("FAIL rr_hold[%0d]: got %b expected %b", k, grant, order[k]);
      end
      done = grant;
      step();
      done = 3'b000;
    end
    req = 3'b000;
    step(); step();
  endtask

  task automatic test_watchdog();
    int cnt;
    int seen;
    rst = 1'b1; step(); rst = 1'b0;
    req = 3'b001; slave_busy = 1'b0;
    step();
    cnt = 0;
    while (timeout !== 1'b1 && cnt < 20) begin step(); cnt++; end
    n_run++;
    if (cnt !== T || bus_util !== 1'b0) begin
      n_fail++; $display("FAIL wd_expiry: got %0d cycles bus_util=%b expected %0d cycles bus_util=0", cnt, bus_util, T);
    end
    step();
    n_run++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL wd_pulse_width: got %b expected 0", timeout);
    end
    cnt = 0;
    while (grant !== 3'b001 && cnt < 10) begin step(); cnt++; end
    repeat (3) step();
    slave_busy = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (timeout !== 1'b0 || bus_util !== 1'b1) seen++;
    end
    n_run++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL wd_busy_hold: got %0d bad cycles expected 0", seen);
    end
    slave_busy = 1'b0;
    cnt = 0;
    while (timeout !== 1'b1 && cnt < 20) begin step(); cnt++; end
    n_run++;
    if (cnt !== T) begin
      n_fail++; $display("FAIL wd_restart: got %0d cycles expected %0d", cnt, T);
    end
    req = 3'b000;
    step(); step(); step();
  endtask

  task automatic test_deferral();
    int hits;
    slave_busy = 1'b1; req = 3'b100;
    hits = 0;
    repeat (6) begin step(); if (grant !== 3'b000) hits++; end
    n_run++;
    if (hits !== 0) begin
      n_fail++; $display("FAIL defer_hold: got %0d granted cycles expected 0", hits);
    end
    slave_busy = 1'b0;
    step();
    n_run++;
    if ({grant, grant_id} !== 5'b100_10) begin
      n_fail++; $display("FAIL defer_grant: got %b expected %b", {grant, grant_id}, 5'b100_10);
    end
    done = 3'b100; req = 3'b000;
    step();
    done = 3'b000;
    step(); step();
  endtask

  task automatic test_abort();
    rst = 1'b1; step(); rst = 1'b0;
    req = 3'b001;
    step(); step(); step();
    req = 3'b000;
    step();
    n_run++;
    if ({grant, bus_util, timeout} !== 5'b0) begin
      n_fail++; $display("FAIL abort_release: got %b expected %b", {grant, bus_util, timeout}, 5'b0);
    end
    step(); step();
    req = 3'b001;
    step();
    repeat (T - 1) step();
    done = 3'b001;
    step();
    done = 3'b000;
    n_run++;
    if ({grant, timeout} !== 4'b0) begin
      n_fail++; $display("FAIL done_vs_watchdog: got %b expected %b", {grant, timeout}, 4'b0);
    end
    req = 3'b000;
    step(); step();
    req = 3'b011;
    step();
    done = 3'b001;
    step();
    done = 3'b000;
    n_run++;
    if ({grant, bus_util, timeout} !== 5'b010_1_0) begin
      n_fail++; $display("FAIL nonowner_done: got %b expected %b", {grant, bus_util, timeout}, 5'b010_1_0);
    end
    done = 3'b010; req = 3'b000;
    step();
    done = 3'b000;
    step(); step();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    req = 3'b100;
    step();
    n_run++;
    if (grant !== 3'b100) begin
      n_fail++; $display("FAIL mid_pre_grant: got %b expected 100", grant);
    end
    step();
    rst = 1'b1;
    step();
    n_run++;
    if ({grant, grant_id, bus_util, timeout} !== 7'b0) begin
      n_fail++; $display("FAIL mid_reset: got %b expected %b", {grant, grant_id, bus_util, timeout}, 7'b0);
    end
    rst = 1'b0; req = 3'b101;
    step();
    n_run++;
    if (grant !== 3'b001) begin
      n_fail++; $display("FAIL mid_first_owner: got %b expected 001", grant);
    end
    req = 3'b000;
    step(); step(); step();
  endtask

  task automatic test_random();
    int prints;
    prints = 0;
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      slave_busy = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) req = req ^ 3'($urandom_range(1, 7));
      done = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step();
      n_run++;
      if ({grant, grant_id, bus_util, timeout} !== exp_vec()) begin
        n_fail++;
        if (prints < 10) begin
          prints++;
          $display("FAIL random_cycle[%0d]: got %b expected %b", c, {grant, grant_id, bus_util, timeout}, exp_vec());
        end
      end
    end
    rst = 1'b0; req = 3'b000; done = 3'b000; slave_busy = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_deferral();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
